// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx - DVP camera-port transmitter (camera emulator).
//
// Takes 16-bit RGB565 pixels on a valid/ready stream and replays them as an
// 8-bit DVP byte stream (high byte first) with HREF/VSYNC framing. All line
// and frame timing comes from parameters. The line never stalls: if no
// pixel is offered in a slot, zeros are sent and o_underrun is flagged.
//
// Handshake: s_ready is combinational from state/counters. A pixel is taken
// at a rising edge where s_ready && s_valid. If s_ready is high and s_valid
// is low, the slot is still consumed (sent as 0x00,0x00) because the line
// timing cannot be delayed.
//
// Ports:
//   i_pclk        byte clock, all logic on rising edge
//   i_rst_n       asynchronous active-low reset
//   i_enable      frames start only while high (level)
//   s_pixel       RGB565 pixel, [15:8] sent first
//   s_valid       s_pixel valid
//   s_ready       pixel slot open this cycle
//   CAM_RGB       byte bus (0 outside active bytes)
//   HREF          high during active bytes
//   VSYNC         high during sync lines
//   o_frame_start one-cycle pulse on first VSYNC cycle
//   o_underrun    sticky: a pixel slot was missed this frame
//   o_busy        frame in progress
//   dbg_state     current FSM state (debug observation)
module cam_dvp_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic        i_pclk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [15:0] s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  CAM_RGB,
    output logic        HREF,
    output logic        VSYNC,
    output logic        o_frame_start,
    output logic        o_underrun,
    output logic        o_busy,
    output logic [2:0]  dbg_state
);

    localparam int L     = 2 * H_ACTIVE + H_BLANK;
    localparam int LINES = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW    = (L > 1) ? $clog2(L) : 1;
    localparam int VW    = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(L - 1);
    localparam logic [HW-1:0] H_BYTES = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] V_LAST  = VW'(LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [HW-1:0]   h_cnt, h_next;
    logic [VW-1:0]   v_cnt, v_next;
    logic [7:0]      low_byte;
    logic            byte_hi;   // first byte slot of a pixel (== s_ready)
    logic            byte_lo;   // second byte slot of a pixel
    logic            sof;       // first cycle of a frame, decoded

    // Vertical region of a line index. Zero-length regions fall through
    // naturally, which is how VBP/VFP are skipped when their count is 0.
    function automatic state_t region(input logic [VW-1:0] v);
        if (32'(v) < V_SYNC)
            return ST_SYNC;
        else if (32'(v) < V_SYNC + V_BP)
            return ST_VBP;
        else if (32'(v) < V_SYNC + V_BP + V_ACTIVE)
            return ST_ACTIVE;
        else
            return ST_VFP;
    endfunction

    // State and counter register.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        if (state == ST_IDLE) begin
            if (i_enable) begin
                state_next = ST_SYNC;
                h_next     = '0;
                v_next     = '0;
            end
        end else if (h_cnt == H_LAST) begin
            h_next = '0;
            if (v_cnt == V_LAST) begin
                // Frame end: i_enable decides between back-to-back and idle.
                v_next     = '0;
                state_next = i_enable ? ST_SYNC : ST_IDLE;
            end else begin
                v_next     = v_cnt + 1'b1;
                state_next = region(v_cnt + 1'b1);
            end
        end else begin
            h_next = h_cnt + 1'b1;
        end
    end

    always_comb begin
        byte_hi = (state == ST_ACTIVE) && !h_cnt[0] && (h_cnt < H_BYTES);
        byte_lo = (state == ST_ACTIVE) &&  h_cnt[0] && (h_cnt < H_BYTES);
        sof     = (state == ST_SYNC) && (h_cnt == '0) && (v_cnt == '0);
    end

    assign s_ready   = byte_hi;
    assign o_busy    = (state != ST_IDLE);
    assign dbg_state = state;

    // Registered DVP outputs; they lag the counter decode by one cycle.
    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            CAM_RGB       <= '0;
            HREF          <= 1'b0;
            VSYNC         <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
            low_byte      <= '0;
        end else begin
            VSYNC         <= (state == ST_SYNC);
            o_frame_start <= sof;
            if (byte_hi) begin
                CAM_RGB  <= s_valid ? s_pixel[15:8] : 8'h00;
                low_byte <= s_valid ? s_pixel[7:0]  : 8'h00;
                HREF     <= 1'b1;
            end else if (byte_lo) begin
                CAM_RGB <= low_byte;
                HREF    <= 1'b1;
            end else begin
                CAM_RGB <= '0;
                HREF    <= 1'b0;
            end
            // Cleared as the new frame starts; a slot miss cannot happen in
            // SYNC, so set and clear never collide.
            if (sof)
                o_underrun <= 1'b0;
            else if (byte_hi && !s_valid)
                o_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// tb_cam_dvp_tx - self-checking bench for cam_dvp_tx.
//
// The reference model tracks frame position as a plain cycle index into the
// frame and derives line/column by division, predicting every output one
// edge ahead. Expected bytes go through a queue filled at each accept.
// Run-length monitors add direct timing checks (VSYNC length, first HREF
// offset, frame-start period, HREF burst length, frame duration).
module tb_cam_dvp_tx;

    localparam int HA  = 4;
    localparam int HB  = 6;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VA  = 3;
    localparam int VFP = 1;
    localparam int L   = 2 * HA + HB;          // 14
    localparam int NL  = VS + VBP + VA + VFP;  // 7
    localparam int F   = L * NL;               // 98

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [15:0] s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  CAM_RGB;
    logic        HREF;
    logic        VSYNC;
    logic        o_frame_start;
    logic        o_underrun;
    logic        o_busy;
    logic [2:0]  dbg_state;

    cam_dvp_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS),
        .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut (
        .i_pclk(clk),
        .i_rst_n(rst_n),
        .i_enable(i_enable),
        .s_pixel(s_pixel),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .CAM_RGB(CAM_RGB),
        .HREF(HREF),
        .VSYNC(VSYNC),
        .o_frame_start(o_frame_start),
        .o_underrun(o_underrun),
        .o_busy(o_busy),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // model state
    logic       m_busy;
    int         m_pos;
    logic [7:0] e_cam;
    logic       e_href, e_vsync, e_fs, e_under;
    logic [7:0] exp_q[$];
    logic [15:0] pat;

    // monitors
    int   cyc;
    logic prev_vs, prev_href, prev_busy;
    int   vs_run, href_run, busy_run, vs_rise_cyc, last_fs;
    logic href_armed, fs_valid, saw_idle;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic ready_of(input logic busy, input int pos);
        int line, col;
        line = pos / L;
        col  = pos % L;
        return busy && line >= VS + VBP && line < VS + VBP + VA
               && col < 2 * HA && (col % 2) == 0;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_pos = 0;
        e_cam = 8'h00; e_href = 1'b0; e_vsync = 1'b0; e_fs = 1'b0; e_under = 1'b0;
        exp_q.delete();
        prev_vs = 1'b0; prev_href = 1'b0; prev_busy = 1'b0;
        vs_run = 0; href_run = 0; busy_run = 0;
        href_armed = 1'b0; fs_valid = 1'b0; saw_idle = 1'b0;
    endtask

    task automatic check_outputs();
        cyc++;
        chk("cam",   CAM_RGB,       e_cam);
        chk("href",  HREF,          e_href);
        chk("vsync", VSYNC,         e_vsync);
        chk("fs",    o_frame_start, e_fs);
        chk("under", o_underrun,    e_under);
        chk("busy",  o_busy,        m_busy);
        chk("ready", s_ready,       ready_of(m_busy, m_pos));
        // VSYNC run length and first-HREF offset
        if (VSYNC && !prev_vs) begin
            vs_rise_cyc = cyc;
            href_armed  = 1'b1;
        end
        if (VSYNC) vs_run++;
        if (!VSYNC && prev_vs) chk("vsync_len", vs_run, VS * L);
        if (!VSYNC) vs_run = 0;
        if (HREF && !prev_href && href_armed) begin
            chk("href_first", cyc - vs_rise_cyc, (VS + VBP) * L);
            href_armed = 1'b0;
        end
        if (HREF) href_run++;
        if (!HREF && prev_href) chk("href_len", href_run, 2 * HA);
        if (!HREF) href_run = 0;
        // frame-start period across back-to-back frames
        if (o_frame_start) begin
            if (fs_valid && !saw_idle) chk("fs_period", cyc - last_fs, F);
            last_fs  = cyc;
            fs_valid = 1'b1;
            saw_idle = 1'b0;
        end
        if (!o_busy) saw_idle = 1'b1;
        // a busy stretch is a whole number of frames
        if (o_busy) busy_run++;
        if (!o_busy && prev_busy) chk("busy_len", busy_run % F, 0);
        if (!o_busy) busy_run = 0;
        prev_vs = VSYNC; prev_href = HREF; prev_busy = o_busy;
    endtask

    // Drive inputs for the coming edge and predict what that edge produces.
    task automatic drive(input logic en, input logic vld, input logic [15:0] pix);
        int   line, col;
        logic rdy, act;
        i_enable = en; s_valid = vld; s_pixel = pix;
        line = m_pos / L;
        col  = m_pos % L;
        rdy  = ready_of(m_busy, m_pos);
        act  = m_busy && line >= VS + VBP && line < VS + VBP + VA;
        if (rdy) begin
            exp_q.push_back(vld ? pix[15:8] : 8'h00);
            exp_q.push_back(vld ? pix[7:0]  : 8'h00);
        end
        e_vsync = m_busy && line < VS;
        e_fs    = m_busy && m_pos == 0;
        e_href  = act && col < 2 * HA;
        if (e_href && exp_q.size() > 0) e_cam = exp_q.pop_front();
        else e_cam = 8'h00;
        if (e_fs) e_under = 1'b0;
        else if (rdy && !vld) e_under = 1'b1;
        if (!m_busy) begin
            if (en) begin m_busy = 1'b1; m_pos = 0; end
        end else if (m_pos == F - 1) begin
            m_pos  = 0;
            m_busy = en;
        end else begin
            m_pos++;
        end
    endtask

    task automatic pat_cycle(input logic en, input logic drop);
        logic rdy;
        @(negedge clk);
        check_outputs();
        rdy = ready_of(m_busy, m_pos);
        drive(en, !drop, pat);
        if (rdy && !drop) pat = pat + 16'h4444;
    endtask

    task automatic rnd_cycle(input logic en);
        @(negedge clk);
        check_outputs();
        drive(en, $urandom_range(0, 9) != 0, 16'($urandom));
    endtask

    initial begin
        logic hit;
        logic drop;
        cyc = 0;
        pat = 16'h1234;
        rst_n = 1'b0; i_enable = 1'b1; s_valid = 1'b1; s_pixel = 16'h0;
        model_reset();

        // reset held with i_enable high: everything stays 0
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        drive(1'b1, 1'b1, pat);

        // two full frames of the counting pattern, s_valid always high
        repeat (2 * F) pat_cycle(1'b1, 1'b0);

        // underrun: drop the 3rd pixel of active line 2, then one clean frame
        repeat (F) begin
            drop = m_busy && (m_pos / L) == VS + VBP + 1 && (m_pos % L) == 4;
            pat_cycle(1'b1, drop);
        end
        repeat (F) pat_cycle(1'b1, 1'b0);

        // drop i_enable during active line 1; frame must complete then idle
        hit = 1'b0;
        for (int i = 0; i < 2 * F; i++) begin
            pat_cycle(1'b1, 1'b0);
            if (m_busy && m_pos == (VS + VBP) * L + 3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_active", hit, 1'b1);
        repeat (F + 20) pat_cycle(1'b0, 1'b0);

        // restart, then reset mid-line while HREF is high
        hit = 1'b0;
        for (int i = 0; i < 3 * F; i++) begin
            pat_cycle(1'b1, 1'b0);
            if (e_href) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_href", hit, 1'b1);
        @(posedge clk);
        #1;
        chk("href_before_rst", HREF, e_href);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_href",  HREF,    1'b0);
        chk("rst_cam",   CAM_RGB, 8'h00);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_busy",  o_busy,  1'b0);
        model_reset();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        drive(1'b1, 1'b1, pat);
        repeat (F + 10) pat_cycle(1'b1, 1'b0);

        // random pixels, random valid gaps, rare enable drops
        repeat (4 * F) rnd_cycle($urandom_range(0, 99) != 0);
        repeat (F + 20) rnd_cycle(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
